// File: rtl/stage_sequencer.sv
// Single-clock stage sequencer for the multi-cycle RV32 core: one-hot FT/DC/EX/MA/WB
// enables, EX stretched by the extension ALU, MA stretched by memWait with optional timeout.
module stage_sequencer #(
    parameter int EX_MIN_CYCLES = 1,
    parameter int MEM_TIMEOUT   = 255,
    parameter int CNT_W         = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             halt,
    input  logic             rwmem,
    input  logic             exUse,
    input  logic             exBusy,
    input  logic             memWait,
    output logic             enFT,
    output logic             enDC,
    output logic             enEX,
    output logic             enMA,
    output logic             enWB,
    output logic [2:0]       stage,
    output logic [CNT_W-1:0] retired,
    output logic             memTimeout
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FT   = 3'd1,
        S_DC   = 3'd2,
        S_EX   = 3'd3,
        S_MA   = 3'd4,
        S_WB   = 3'd5
    } state_t;

    // ex_cnt saturates, so it only needs to reach EX_MIN_CYCLES-1 and 1.
    localparam int EX_W   = $clog2(EX_MIN_CYCLES + 2);
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            state;
    state_t            nxt;
    logic [EX_W-1:0]   ex_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              ex_done;
    logic              wait_expire;

    always_comb begin
        // exBusy is ignored in the ALU start cycle (ex_cnt == 0)
        ex_done     = (int'(ex_cnt) >= EX_MIN_CYCLES - 1) &&
                      (!exUse || (ex_cnt != '0 && !exBusy));
        wait_expire = (MEM_TIMEOUT != 0) && memWait && (wait_cnt == WAIT_LAST);
        nxt = state;
        case (state)
            S_IDLE:  if (!halt) nxt = S_FT;
            S_FT:    nxt = S_DC;
            S_DC:    nxt = S_EX;
            S_EX:    if (ex_done) nxt = rwmem ? S_MA : S_WB;
            S_MA:    if (!memWait || wait_expire) nxt = S_WB;
            S_WB:    nxt = halt ? S_IDLE : S_FT;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            stage      <= 3'd0;
            enFT       <= 1'b0;
            enDC       <= 1'b0;
            enEX       <= 1'b0;
            enMA       <= 1'b0;
            enWB       <= 1'b0;
            retired    <= '0;
            memTimeout <= 1'b0;
            ex_cnt     <= '0;
            wait_cnt   <= '0;
        end else begin
            state <= nxt;
            stage <= nxt;
            enFT  <= (nxt == S_FT);
            enDC  <= (nxt == S_DC);
            enEX  <= (nxt == S_EX);
            enMA  <= (nxt == S_MA);
            enWB  <= (nxt == S_WB);
            // WB never repeats, so nxt==WB marks exactly one retirement
            if (nxt == S_WB) retired <= retired + CNT_W'(1);
            if (state == S_EX && nxt == S_EX) begin
                if (ex_cnt != '1) ex_cnt <= ex_cnt + EX_W'(1);
            end else begin
                ex_cnt <= '0;
            end
            if (state == S_MA && nxt == S_MA) wait_cnt <= wait_cnt + WAIT_W'(1);
            else                              wait_cnt <= '0;
            if (state == S_MA && wait_expire) memTimeout <= 1'b1;
        end
    end
endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Single-clock, enable-based replacement for the phase-clock generator of the multi-cycle RV32 core.
- Emits one-hot stage enables FT/DC/EX/MA/WB that gate the ROM, register file, extension ALU, MMU and PC/register write-back on the common CLK.
- Stretches EX while the 256-bit extension ALU is busy and MA while the MMU asserts memWait.
- Skips MA for non-memory instructions and counts retired instructions.

Parameters:
EX_MIN_CYCLES, 1, minimum cycles spent in EX for every instruction (≥1)
MEM_TIMEOUT, 255, max consecutive memWait cycles in MA before forced exit; 0 disables timeout
CNT_W, 32, width of retired-instruction counter

Ports:
CLK  input  1  system clock, all state updates on rising edge
RST  input  1  synchronous, active-high reset
halt  input  1  request to stop issuing; honoured only at instruction boundary
rwmem  input  1  from controller: current instruction accesses memory (MA required)
exUse  input  1  from controller: current instruction uses extension ALU
exBusy  input  1  extension ALU busy
memWait  input  1  MMU not ready
enFT  output  1  fetch enable (ROM latch INST)
enDC  output  1  decode enable (register read)
enEX  output  1  execute enable
enMA  output  1  memory-access enable (MMU clock-enable)
enWB  output  1  write-back enable (PC and register write)
stage  output  3  current state code: IDLE=0 FT=1 DC=2 EX=3 MA=4 WB=5
retired  output  CNT_W  instructions completed (WB cycles), wraps
memTimeout  output  1  sticky: an MA wait hit MEM_TIMEOUT

Behaviour:
- Reset (RST=1 at edge): state IDLE, all en* = 0, stage = 0, retired = 0, memTimeout = 0, internal counters cleared. Reset mid-instruction aborts it; no enWB is emitted for the aborted instruction.
- Outputs are Moore: enX = (state==X); exactly one enable high outside IDLE, none in IDLE.
- IDLE: halt=0 → FT next cycle; halt=1 → stay.
- FT → DC → EX: one cycle each, unconditional.
- EX: cycle counter exCnt starts at 0 on entry and increments each EX cycle.
- EX exit when exCnt ≥ EX_MIN_CYCLES−1 AND (exUse=0 OR (exCnt ≥ 1 AND exBusy=0)).
- With exUse=1, exBusy is ignored in the first EX cycle (start cycle), so EX lasts ≥2 cycles.
- EX successor: rwmem=1 → MA, rwmem=0 → WB. rwmem and exUse are sampled in the exit cycle.
- MA: minimum 1 cycle. Exit to WB on the first cycle with memWait=0.
- MA wait counter: waitCnt counts consecutive MA cycles with memWait=1.
- If MEM_TIMEOUT≠0 and waitCnt reaches MEM_TIMEOUT: set memTimeout=1 (sticky until RST) and go to WB.
- WB: exactly one cycle; retired increments by 1 (modulo 2^CNT_W, 0xFFFFFFFF→0 for CNT_W=32).
- WB successor: halt=1 → IDLE, else FT.
- halt asserted/deasserted during FT..MA has no effect until the WB decision; halt is never sampled mid-instruction.
- Simultaneous memWait deassertion and timeout-count cycle: normal exit, memTimeout not set.
- Minimum instruction: 4 cycles (FT,DC,EX,WB) with EX_MIN_CYCLES=1, rwmem=0, exUse=0. Back-to-back instructions have no IDLE gap.

Test Plan:
- Reset then halt=0, rwmem=0, exUse=0: stage sequence 1,2,3,5,1,… (4 cycles/instr); after 10 instructions retired=10; enMA never high.
- rwmem=1, memWait held 1 for 3 MA cycles then 0: MA lasts 4 cycles, enWB one cycle later, memTimeout=0.
- exUse=1, exBusy high for EX cycles 0–4 and low at cycle 5: EX occupies exactly 6 cycles, then MA or WB per rwmem.
- MEM_TIMEOUT=8, rwmem=1, memWait stuck 1: MA exits to WB after 8 wait cycles; memTimeout=1 and remains 1 across later instructions until RST.
- halt raised during EX: instruction completes through WB, then stage=0, all enables 0. halt dropped: FT on the next cycle.
- RST asserted in MA of an instruction with retired=5: next cycle stage=0, retired=0, no enWB pulse. Separately, preload near wrap (CNT_W=4, 16 instructions): retired wraps 15→0.
